// File: rtl/fixedpoint_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fixedpoint
// Description : Q8.8 fixed-point type, activation-mode encoding and the Q8.8
//               multiply helper shared by the activation datapath.
// Contents    : fixed_point_t, FP_FRAC_BITS, act_mode_t, fp_mul_q88()
// Revision    : 1.0 - initial release
// ============================================================================
package fixedpoint;

    typedef logic signed [15:0] fixed_point_t;

    localparam int FP_FRAC_BITS = 8;

    typedef enum logic [1:0] {
        LEAKY = 2'd0,
        RELU  = 2'd1,
        IDENT = 2'd2
    } act_mode_t;

    // Full 32-bit signed product, arithmetic shift (floor), keep low 16 bits.
    function automatic fixed_point_t fp_mul_q88(input fixed_point_t a,
                                                input fixed_point_t b);
        logic signed [31:0] prod;
        logic signed [31:0] shifted;
        prod    = 32'(a) * 32'(b);
        shifted = prod >>> FP_FRAC_BITS;
        return shifted[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/act_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Search starts one past the last granted
//               requester; the pointer moves only when a grant is issued
//               while enabled (grant implies a transfer, since grant is only
//               given to an asserted request).
// Ports       : clk, rst      - clock, synchronous active-high reset
//               req [N_REQ]   - request vector
//               en            - grants allowed this cycle
//               grant [N_REQ] - one-hot (or zero) grant, combinational
//               grant_id      - index of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id
);

    localparam logic [ID_W-1:0] C_LAST_RST = ID_W'(N_REQ - 1);
    localparam logic [ID_W:0]   C_N_EXT    = (ID_W + 1)'(N_REQ);

    logic [ID_W-1:0] last_grant_q;
    logic [ID_W-1:0] last_grant_d;
    logic            found;

    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            // Candidate (last_grant + k) mod N_REQ; one extra bit holds the carry.
            sum = {1'b0, last_grant_q} + (ID_W + 1)'(k);
            if (sum >= C_N_EXT) begin
                sum = sum - C_N_EXT;
            end
            idx = sum[ID_W-1:0];
            if (en && !found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

    assign last_grant_d = found ? grant_id : last_grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= C_LAST_RST;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/act_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : act_scheduler
// Description : Shares one 2-stage leaky-ReLU / ReLU / identity activation
//               unit among N_REQ accumulators. A round-robin arbiter admits
//               one sum per cycle into S1 (capture); the activated result is
//               registered in S2 and leaves tagged with the requester index.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               cfg_mode, cfg_coeff      - activation select / leaky slope
//               req_valid/req_data/req_ready - per-requester valid/ready inputs
//               out_valid/out_data/out_id/out_ready - tagged result stream
//               busy                     - either stage occupied
//               result_count             - results delivered (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module act_scheduler
    import fixedpoint::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            cfg_mode,
    input  logic [15:0]           cfg_coeff,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*16-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  out_valid,
    output logic [15:0]           out_data,
    output logic [ID_W-1:0]       out_id,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [15:0]           result_count
);

    // S1 capture stage
    logic         v1_q, v1_d;
    fixed_point_t s1_data_q, s1_data_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    act_mode_t    s1_mode_q, s1_mode_d;
    fixed_point_t s1_coeff_q, s1_coeff_d;
    // S2 output stage
    logic         v2_q, v2_d;
    fixed_point_t out_data_q, out_data_d;
    logic [ID_W-1:0] out_id_q, out_id_d;
    logic [15:0]  count_q, count_d;

    logic            adv1, adv2;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0] grant_id;
    fixed_point_t    sel_data;
    fixed_point_t    act_res;

    assign adv2 = !v2_q || out_ready;
    assign adv1 = !v1_q || adv2;

    // Reset gates the enable so no requester sees ready during reset.
    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .en       (adv1 && !rst),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready = grant;

    // One-hot mux of the granted requester's sum.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_data = req_data[i*16 +: 16];
            end
        end
    end

    // Activation between S1 and S2; non-negative inputs pass in every mode.
    always_comb begin
        act_res = s1_data_q;
        if (s1_data_q[15]) begin
            case (s1_mode_q)
                RELU:    act_res = '0;
                IDENT:   act_res = s1_data_q;
                default: act_res = fp_mul_q88(s1_data_q, s1_coeff_q);
            endcase
        end
    end

    always_comb begin
        v1_d       = v1_q;
        s1_data_d  = s1_data_q;
        s1_id_d    = s1_id_q;
        s1_mode_d  = s1_mode_q;
        s1_coeff_d = s1_coeff_q;
        v2_d       = v2_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        count_d    = count_q;

        if (adv1) begin
            v1_d = |grant;
            if (|grant) begin
                s1_data_d  = sel_data;
                s1_id_d    = grant_id;
                // Mode 3 is folded onto leaky ReLU at capture.
                s1_mode_d  = (cfg_mode == 2'd3) ? LEAKY : act_mode_t'(cfg_mode);
                s1_coeff_d = cfg_coeff;
            end
        end
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                out_data_d = act_res;
                out_id_d   = s1_id_q;
            end
        end
        if (v2_q && out_ready) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q       <= 1'b0;
            s1_data_q  <= '0;
            s1_id_q    <= '0;
            s1_mode_q  <= LEAKY;
            s1_coeff_q <= '0;
            v2_q       <= 1'b0;
            out_data_q <= '0;
            out_id_q   <= '0;
            count_q    <= '0;
        end else begin
            v1_q       <= v1_d;
            s1_data_q  <= s1_data_d;
            s1_id_q    <= s1_id_d;
            s1_mode_q  <= s1_mode_d;
            s1_coeff_q <= s1_coeff_d;
            v2_q       <= v2_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
            count_q    <= count_d;
        end
    end

    assign out_valid    = v2_q;
    assign out_data     = out_data_q;
    assign out_id       = out_id_q;
    assign busy         = v1_q || v2_q;
    assign result_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_act_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_act_scheduler
// Description : Self-checking bench for act_scheduler. A transaction-level
//               model (in-flight queue of at most two items, round-robin
//               pointer, delivered counter) predicts every output each cycle;
//               directed scenarios pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_act_scheduler;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    cfg_mode = 2'd0;
    logic [15:0]   cfg_coeff = 16'h0010;
    logic [N-1:0]  req_valid = '0;
    logic [N*16-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic          out_valid;
    logic [15:0]   out_data;
    logic [1:0]    out_id;
    logic          out_ready = 1'b1;
    logic          busy;
    logic [15:0]   result_count;

    act_scheduler #(.N_REQ(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_mode     (cfg_mode),
        .cfg_coeff    (cfg_coeff),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_id       (out_id),
        .out_ready    (out_ready),
        .busy         (busy),
        .result_count (result_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected activation from the arithmetic definition (floor division).
    function automatic logic [15:0] exp_act(input logic [15:0] x, input logic [1:0] m,
                                            input logic [15:0] c);
        int xi, p, qv;
        xi = int'($signed(x));
        if (xi >= 0 || m == 2'd2) return x;
        if (m == 2'd1) return 16'h0000;
        p  = xi * int'(c);
        qv = p / 256;
        if (p % 256 != 0) qv = qv - 1;
        return 16'(qv);
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    typedef struct {
        logic [15:0] res;
        int          id;
        int          t;    // edge number at which the item was accepted
    } item_t;

    item_t       mq[$];
    int          m_last  = N - 1;
    logic [15:0] m_count = '0;
    int          ecnt    = 0;
    bit          chk_en  = 1'b0;

    logic [N-1:0] c_er;
    int           c_g;
    bit           c_acc, c_ev;

    always @(negedge clk) begin
        if (chk_en) begin
            c_ev  = (mq.size() > 0) && (ecnt >= mq[0].t + 1);
            c_acc = (mq.size() < 2) || out_ready;
            c_g   = rr_pick(req_valid, m_last);
            c_er  = '0;
            if (!rst && c_acc && c_g >= 0) c_er[c_g] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(c_er));
            check("out_valid", 32'(out_valid), 32'(c_ev));
            if (c_ev) begin
                check("out_data", 32'(out_data), 32'(mq[0].res));
                check("out_id", 32'(out_id), 32'(mq[0].id));
            end
            check("busy", 32'(busy), 32'(mq.size() > 0));
            check("result_count", 32'(result_count), 32'(m_count));
            if (rst) begin
                mq.delete();
                m_last  = N - 1;
                m_count = '0;
            end else begin
                if (c_ev && out_ready) begin
                    void'(mq.pop_front());
                    m_count = m_count + 16'd1;
                end
                if (c_er != '0) begin
                    mq.push_back('{exp_act(req_data[c_g*16 +: 16], cfg_mode, cfg_coeff),
                                   c_g, ecnt + 1});
                    m_last = c_g;
                end
            end
        end
        ecnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            sample();
            if (out_valid) ok = 1'b1;
            else step();
        end
    endtask

    task automatic run_one(input string nm, input logic [15:0] x, input logic [1:0] m,
                           input logic [15:0] c, input logic [15:0] expv);
        bit ok;
        cfg_mode  = m;
        cfg_coeff = c;
        req_data  = '0;
        req_data[15:0] = x;
        req_valid = 4'b0001;
        out_ready = 1'b1;
        step();
        req_valid = '0;
        wait_out(ok);
        check({nm, " valid"}, 32'(ok), 32'd1);
        if (ok) begin
            check({nm, " data"}, 32'(out_data), 32'(expv));
            check({nm, " id"}, 32'(out_id), 32'd0);
        end
        step();
    endtask

    int ids[$];
    int first_cyc, last_cyc, acc_cnt;
    logic [15:0] snap_d;
    logic [1:0]  snap_i;
    bit ok2;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Pin the model against hand-computed values.
        check("model leaky", 32'(exp_act(16'hFE00, 2'd0, 16'h0010)), 32'h0000FFE0);
        check("model floor -1", 32'(exp_act(16'hFFFF, 2'd0, 16'h0010)), 32'h0000FFFF);
        check("model min", 32'(exp_act(16'h8000, 2'd0, 16'h00FF)), 32'h00008080);
        check("model rr", 32'(rr_pick(4'b1010, 1)), 32'd3);

        step();
        chk_en = 1'b1;
        rst    = 1'b0;

        // Directed single items.
        run_one("basic leaky", 16'hFE00, 2'd0, 16'h0010, 16'hFFE0);
        sample();
        check("count after first", 32'(result_count), 32'd1);
        step();
        run_one("positive", 16'h0380, 2'd0, 16'h0010, 16'h0380);
        run_one("relu neg", 16'hFE00, 2'd1, 16'h0010, 16'h0000);
        run_one("ident neg", 16'hFE00, 2'd2, 16'h0010, 16'hFE00);
        run_one("mode3 leaky", 16'hFE00, 2'd3, 16'h0010, 16'hFFE0);
        run_one("floor -1", 16'hFFFF, 2'd0, 16'h0010, 16'hFFFF);
        run_one("floor min", 16'h8000, 2'd0, 16'h00FF, 16'h8080);

        // Fairness: all valid, no back-pressure.
        do_reset();
        cfg_mode = 2'd2;
        req_data = {16'h0344, 16'h0233, 16'h0122, 16'h0011};
        req_valid = 4'b1111;
        out_ready = 1'b1;
        ids.delete();
        first_cyc = -1;
        last_cyc  = -1;
        for (int c = 0; c < 30 && ids.size() < 8; c++) begin
            sample();
            if (out_valid) begin
                ids.push_back(int'(out_id));
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
            end
            step();
        end
        check("fair count", 32'(ids.size()), 32'd8);
        check("fair 1/cycle", 32'(last_cyc - first_cyc), 32'd7);
        for (int i = 0; i < ids.size(); i++) check("fair id", 32'(ids[i]), 32'(i % 4));
        req_valid = '0;
        repeat (3) step();

        // Back-pressure: 5 stalled cycles admit exactly two items.
        do_reset();
        out_ready = 1'b0;
        req_valid = 4'b1111;
        acc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            sample();
            if (req_ready != '0) acc_cnt++;
            step();
        end
        check("bp accepted", 32'(acc_cnt), 32'd2);
        sample();
        check("bp ready low", 32'(req_ready), 32'd0);
        check("bp valid", 32'(out_valid), 32'd1);
        snap_d = out_data;
        snap_i = out_id;
        step();
        sample();
        check("bp hold data", 32'(out_data), 32'(snap_d));
        check("bp hold id", 32'(out_id), 32'(snap_i));
        step();
        req_valid = '0;
        out_ready = 1'b1;
        ids.delete();
        for (int c = 0; c < 10; c++) begin
            sample();
            if (out_valid) ids.push_back(int'(out_id));
            step();
        end
        check("bp delivered", 32'(ids.size()), 32'd2);
        if (ids.size() == 2) begin
            check("bp order 0", 32'(ids[0]), 32'd0);
            check("bp order 1", 32'(ids[1]), 32'd1);
        end

        // Reset with both stages full.
        out_ready = 1'b0;
        req_valid = 4'b1111;
        repeat (3) step();
        sample();
        check("pre-reset busy", 32'(busy), 32'd1);
        step();
        rst = 1'b1;
        step();
        sample();
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst count", 32'(result_count), 32'd0);
        step();
        rst = 1'b0;
        sample();
        check("rst first grant", 32'(req_ready), 32'd1);
        step();

        // Randomized traffic; the compare process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            req_valid = 4'($urandom);
            req_data  = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) cfg_mode = 2'($urandom);
            if ($urandom_range(0, 19) == 0) cfg_coeff = 16'($urandom_range(0, 255));
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/act_scheduler.md
# act_scheduler

Shares one pipelined leaky-ReLU activation unit among `N_REQ` neuron accumulators. Each neuron presents its finished weighted sum on a valid/ready port. A round-robin arbiter grants one sum per cycle into a 2-stage activation pipeline. The result leaves tagged with the requester ID toward the next layer's input buffer. Arithmetic uses `fixed_point_t` from `fixedpoint`: 16-bit signed, Q8.8.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..16.
- `ID_W`, `$clog2(N_REQ)`: width of the requester tag.

Ports:
- `clk`, in, 1: single clock. All logic on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `cfg_mode`, in, 2: activation select, sampled at stage 1.
  - 0: leaky ReLU.
  - 1: plain ReLU.
  - 2: identity.
  - 3: treated as 0.
- `cfg_coeff`, in, 16: leaky slope, Q8.8. Legal range 16'h0000..16'h00FF, i.e. 0 ≤ slope < 1.
- `req_valid`, in, N_REQ: requester i has a sum.
- `req_data`, in, N_REQ×16: `fixed_point_t` sum per requester.
- `req_ready`, out, N_REQ: one-hot grant. Transfer occurs on `req_valid[i] && req_ready[i]`.
- `out_valid`, out, 1: result available.
- `out_data`, out, 16: activated `fixed_point_t`.
- `out_id`, out, ID_W: index of the originating requester.
- `out_ready`, in, 1: downstream accepts.
- `busy`, out, 1: any pipeline stage occupied.
- `result_count`, out, 16: results delivered since reset; wraps at 65535 → 0.

## Operation
Pipeline:
- Stage S1 is the capture register: data, id, mode and coeff, plus a valid bit v1.
- Stage S2 is the output register: `out_data`, `out_id`, and `out_valid` (v2).
- Advance condition: `adv2 = !v2 || out_ready`, and `adv1 = !v1 || adv2`.
- When `adv1` is low, all `req_ready` are 0.

Arbitration:
- Round-robin over `req_valid`.
- Priority search starts at `last_grant + 1` (mod N_REQ).
- `last_grant` updates only on an actual transfer.
- On reset `last_grant = N_REQ-1`, so requester 0 has highest priority.
- `req_ready` is combinational from `req_valid`, `last_grant` and `adv1`.
- `req_ready` is one-hot or zero, and is never asserted to a requester whose `req_valid` is low.

Activation, evaluated between S1 and S2:
- Non-negative x (including 0): result = x in all modes.
- Negative x, mode 1: result = 0.
- Negative x, mode 2: result = x.
- Negative x, mode 0:
  - Form the 32-bit signed product x·coeff.
  - Arithmetic-shift right by 8 (floor) and keep the low 16 bits.
  - No saturation is needed, since |result| ≤ |x| for legal coeff.
- `cfg_coeff` outside the legal range gives undefined results. Verification does not check it.

Counter:
- `result_count` increments on each `out_valid && out_ready`.

## Timing
Reset values:
- `out_valid` = 0, `out_data` = 0, `out_id` = 0.
- `req_ready` = 0 during reset.
- `busy` = 0, `result_count` = 0.
- v1 = 0, `last_grant` = N_REQ-1.

Latency and throughput:
- Latency is 2 cycles. A transfer at edge t sets v1. `out_valid` rises after edge t+1, provided S2 was free or draining.
- Sustained throughput is 1 result/cycle while `out_ready` = 1.

Back-pressure and hold behaviour:
- With `out_ready` = 0 and both stages full, `req_ready` drops to 0.
- S1 and S2 hold their contents unchanged while stalled.
- `out_data`/`out_id` stay stable while `out_valid && !out_ready`.

Configuration timing:
- Config is captured per item in S1. A change in `cfg_mode` mid-stream affects only items granted after the change.

Reset mid-operation:
- Reset asserted mid-operation discards both stages next edge. No partial output is produced.
- `result_count` and `last_grant` are reset as well.

Simultaneous events:
- A new grant into S1 in the same cycle S2 drains is legal and lossless.

## Structure
- Add to `fixedpoint`:
  - `FP_FRAC_BITS = 8`.
  - An `act_mode_t` enum: LEAKY, RELU, IDENT.
  - The function `fp_mul_q88` (32-bit product, `>>> 8`, truncate to 16).
- One sub-module, `rr_arbiter`:
  - Parameter `N_REQ`.
  - Ports: `clk`, `rst`, `req`, `en`, `grant`, `grant_id`.
  - It owns `last_grant`.
- The activation function is combinational inside `act_scheduler`.

## Test plan
- **Basic leaky:** mode 0, coeff 16'h0010, req 0 sends 16'hFE00 (−2.0) → 2 cycles later `out_data` 16'hFFE0 (−0.125), `out_id` 0, `result_count` 1.
- **Positive, ReLU and identity modes:**
  - 16'h0380 in mode 0 → 16'h0380.
  - 16'hFE00 in mode 1 → 16'h0000.
  - 16'hFE00 in mode 2 → 16'hFE00.
- **Floor rounding:** 16'hFFFF with coeff 16'h0010 → 16'hFFFF. 16'h8000 with coeff 16'h00FF → 16'h8080.
- **Fairness:** all 4 requesters valid continuously, `out_ready` = 1 → grants 0,1,2,3,0,… with one result per cycle and matching `out_id` sequence.
- **Back-pressure:**
  - Hold `out_ready` = 0 for 5 cycles with 4 valid requesters → exactly 2 items accepted, `req_ready` = 0 afterwards, outputs stable.
  - Release → items delivered in grant order, no loss or duplication.
- **Reset mid-stream:** `rst` while v1 = v2 = 1 → next cycle `out_valid` 0, `busy` 0, `result_count` 0, requester 0 granted first after release.
